// File: rtl/cdc_pkg.sv
// Shared constants and helpers for clock-domain-crossing blocks.
// Imported by the synchronizer primitives and the bus synchronizers built on them.
package cdc_pkg;

    localparam int DEFAULT_SYNC_STAGES = 2;
    localparam int DEFAULT_BUS_WIDTH   = 8;
    localparam int MIN_SYNC_STAGES     = 2;
    localparam int MAX_SYNC_STAGES     = 4;

    function automatic bit sync_stages_legal(input int stages);
        return (stages >= MIN_SYNC_STAGES) && (stages <= MAX_SYNC_STAGES);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for single-bit (or independent multi-bit) level signals.
// Only the first stage samples the asynchronous input; reset clears the whole chain.
module bit_sync
    import cdc_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_SYNC_STAGES,
    parameter int WIDTH      = 1
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic [WIDTH-1:0] async_data,
    output logic [WIDTH-1:0] sync_data
);

    logic [WIDTH-1:0] stage_q [NUM_STAGES];

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= async_data;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_data = stage_q[NUM_STAGES-1];

endmodule

// File: rtl/data_sync.sv
// Receive-side bus synchronizer: a level qualifier is synchronized and edge-detected,
// the stable bus is captured once per assertion and a valid/ack flag tracks lost words.
module data_sync
    import cdc_pkg::*;
#(
    parameter int NUM_STAGES = DEFAULT_SYNC_STAGES,
    parameter int BUS_WIDTH  = DEFAULT_BUS_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic [BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic                 BUS_EN,
    input  logic                 DATA_ACK,
    output logic [BUS_WIDTH-1:0] SYNC_BUS,
    output logic                 ENABLE_PULSE,
    output logic                 DATA_VALID,
    output logic                 OVERRUN
);

    if (!sync_stages_legal(NUM_STAGES)) begin : g_bad_depth
        $error("data_sync: NUM_STAGES out of legal range");
    end

    logic                 en_sync;
    logic                 en_prev_q;
    logic                 cap;
    logic [BUS_WIDTH-1:0] sync_bus_q;
    logic                 pulse_q;
    logic                 valid_q, valid_d;
    logic                 overrun_q, overrun_d;

    bit_sync #(
        .NUM_STAGES (NUM_STAGES),
        .WIDTH      (1)
    ) u_bus_en_sync (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .async_data (BUS_EN),
        .sync_data  (en_sync)
    );

    // Rising edge of the synchronized qualifier marks a new, already-stable word.
    assign cap = en_sync & ~en_prev_q;

    always_comb begin
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (cap) begin
            valid_d = 1'b1;
            // An ack in the capture cycle consumed the old word, so nothing is lost.
            if (valid_q && !DATA_ACK) begin
                overrun_d = 1'b1;
            end
        end else if (DATA_ACK) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            en_prev_q  <= 1'b0;
            sync_bus_q <= '0;
            pulse_q    <= 1'b0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            en_prev_q <= en_sync;
            pulse_q   <= cap;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
            if (cap) begin
                sync_bus_q <= UNSYNC_BUS;
            end
        end
    end

    assign SYNC_BUS     = sync_bus_q;
    assign ENABLE_PULSE = pulse_q;
    assign DATA_VALID   = valid_q;
    assign OVERRUN      = overrun_q;

endmodule

// File: tb/tb_data_sync.sv
// Bench for data_sync: three instances (2, 3 and 4 stages) share stimulus and are checked
// every cycle against a behavioural model fed by a per-instance queue of expected words.
module tb_data_sync;

    logic       CLK;
    logic       RST_n;
    logic [7:0] UNSYNC_BUS;
    logic       BUS_EN;
    logic       DATA_ACK;

    logic [7:0] sb [2:4];
    logic       ep [2:4];
    logic       dv [2:4];
    logic       ov [2:4];

    // Model state per depth
    logic [7:0] exp_q [2:4][$];
    logic [7:0] m_bus [2:4];
    logic       m_ep [2:4];
    logic       m_valid [2:4];
    logic       m_ovr [2:4];
    int         since_e1;

    int vectors;
    int miscompares;

    data_sync #(.NUM_STAGES(2), .BUS_WIDTH(8)) dut2 (
        .CLK(CLK), .RST_n(RST_n), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN),
        .DATA_ACK(DATA_ACK), .SYNC_BUS(sb[2]), .ENABLE_PULSE(ep[2]),
        .DATA_VALID(dv[2]), .OVERRUN(ov[2])
    );
    data_sync #(.NUM_STAGES(3), .BUS_WIDTH(8)) dut3 (
        .CLK(CLK), .RST_n(RST_n), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN),
        .DATA_ACK(DATA_ACK), .SYNC_BUS(sb[3]), .ENABLE_PULSE(ep[3]),
        .DATA_VALID(dv[3]), .OVERRUN(ov[3])
    );
    data_sync #(.NUM_STAGES(4), .BUS_WIDTH(8)) dut4 (
        .CLK(CLK), .RST_n(RST_n), .UNSYNC_BUS(UNSYNC_BUS), .BUS_EN(BUS_EN),
        .DATA_ACK(DATA_ACK), .SYNC_BUS(sb[4]), .ENABLE_PULSE(ep[4]),
        .DATA_VALID(dv[4]), .OVERRUN(ov[4])
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic reset_model();
        for (int d = 2; d <= 4; d++) begin
            exp_q[d].delete();
            m_bus[d]   = 8'h00;
            m_ep[d]    = 1'b0;
            m_valid[d] = 1'b0;
            m_ovr[d]   = 1'b0;
        end
        since_e1 = -1;
    endtask

    // One clock edge: advance the model, then sample at the following negedge.
    task automatic step();
        logic ack_s;
        logic cap;
        ack_s = DATA_ACK;
        @(posedge CLK);
        if (since_e1 >= 0) since_e1++;
        for (int d = 2; d <= 4; d++) begin
            cap = RST_n && (since_e1 == d + 1);
            m_ep[d] = cap;
            if (cap) begin
                if (exp_q[d].size() > 0) m_bus[d] = exp_q[d].pop_front();
                if (m_valid[d] && !ack_s) m_ovr[d] = 1'b1;
                m_valid[d] = 1'b1;
            end else if (ack_s) begin
                m_valid[d] = 1'b0;
            end
        end
        @(negedge CLK);
        for (int d = 2; d <= 4; d++) begin
            vectors += 4;
            if (ep[d] !== m_ep[d]) begin
                miscompares++;
                $display("FAIL pulse d=%0d k=%0d got %b want %b", d, since_e1, ep[d], m_ep[d]);
            end
            if (sb[d] !== m_bus[d]) begin
                miscompares++;
                $display("FAIL sync_bus d=%0d k=%0d got %h want %h", d, since_e1, sb[d], m_bus[d]);
            end
            if (dv[d] !== m_valid[d]) begin
                miscompares++;
                $display("FAIL valid d=%0d k=%0d got %b want %b", d, since_e1, dv[d], m_valid[d]);
            end
            if (ov[d] !== m_ovr[d]) begin
                miscompares++;
                $display("FAIL overrun d=%0d k=%0d got %b want %b", d, since_e1, ov[d], m_ovr[d]);
            end
        end
    endtask

    // Hold BUS_EN for 'hold' edges; optional ack on edge ack_k and bus change from swap_k on.
    task automatic send_word(input logic [7:0] w, input int hold, input int ack_k,
                             input int swap_k, input logic [7:0] w2);
        UNSYNC_BUS = w;
        BUS_EN     = 1'b1;
        since_e1   = 0;
        for (int d = 2; d <= 4; d++) exp_q[d].push_back(w);
        for (int i = 0; i < hold; i++) begin
            DATA_ACK = (since_e1 + 1 == ack_k);
            if (swap_k > 0 && since_e1 >= swap_k) UNSYNC_BUS = w2;
            step();
        end
        DATA_ACK = 1'b0;
        BUS_EN   = 1'b0;
        for (int i = 0; i < 7; i++) step();
        since_e1 = -1;
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (exp_q[d].size() != 0) begin
                miscompares++;
                $display("FAIL capture_count d=%0d got %0d pending want 0", d, exp_q[d].size());
                exp_q[d].delete();
            end
        end
    endtask

    task automatic pulse_ack();
        DATA_ACK = 1'b1;
        step();
        DATA_ACK = 1'b0;
        step();
    endtask

    task automatic test_reset();
        RST_n      = 1'b1;
        BUS_EN     = 1'b0;
        DATA_ACK   = 1'b0;
        UNSYNC_BUS = 8'h00;
        reset_model();
        #3 RST_n = 1'b0;
        #1;
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if ({sb[d], ep[d], dv[d], ov[d]} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_init d=%0d got %h want 0", d, {sb[d], ep[d], dv[d], ov[d]});
            end
        end
        for (int i = 0; i < 3; i++) step();
        RST_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        send_word(8'hA5, 6, 0, 0, 8'h00);
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (sb[d] !== 8'hA5 || dv[d] !== 1'b1) begin
                miscompares++;
                $display("FAIL basic d=%0d got %h/%b want a5/1", d, sb[d], dv[d]);
            end
        end
    endtask

    task automatic test_long_enable();
        pulse_ack();
        send_word(8'hA5, 20, 0, 6, 8'h3C);
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (sb[d] !== 8'hA5) begin
                miscompares++;
                $display("FAIL long_enable d=%0d got %h want a5", d, sb[d]);
            end
        end
    endtask

    task automatic test_ack();
        pulse_ack();
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (dv[d] !== 1'b0 || ov[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL ack_clear d=%0d got %b/%b want 0/0", d, dv[d], ov[d]);
            end
        end
        pulse_ack();
        send_word(8'h5A, 6, 0, 0, 8'h00);
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (dv[d] !== 1'b1 || sb[d] !== 8'h5A) begin
                miscompares++;
                $display("FAIL ack_second d=%0d got %b/%h want 1/5a", d, dv[d], sb[d]);
            end
        end
    endtask

    task automatic test_overrun();
        pulse_ack();
        send_word(8'h11, 6, 0, 0, 8'h00);
        send_word(8'h22, 6, 0, 0, 8'h00);
        pulse_ack();
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (ov[d] !== 1'b1 || sb[d] !== 8'h22) begin
                miscompares++;
                $display("FAIL overrun_sticky d=%0d got %b/%h want 1/22", d, ov[d], sb[d]);
            end
        end
    endtask

    task automatic test_reset_midcycle_release();
        step();
        #2;
        RST_n      = 1'b0;
        BUS_EN     = 1'b1;
        UNSYNC_BUS = 8'hFF;
        #1;
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if ({sb[d], ep[d], dv[d], ov[d]} !== 11'd0) begin
                miscompares++;
                $display("FAIL reset_async d=%0d got %h want 0", d, {sb[d], ep[d], dv[d], ov[d]});
            end
        end
        reset_model();
        for (int i = 0; i < 4; i++) step();
        RST_n = 1'b1;
        send_word(8'hFF, 8, 0, 0, 8'h00);
    endtask

    task automatic test_ack_on_cap();
        pulse_ack();
        send_word(8'h11, 6, 0, 0, 8'h00);
        send_word(8'h22, 6, 3, 0, 8'h00);
        for (int d = 2; d <= 4; d++) begin
            vectors++;
            if (ov[d] !== 1'b0 || dv[d] !== 1'b1 || sb[d] !== 8'h22) begin
                miscompares++;
                $display("FAIL ack_on_cap d=%0d got %b/%b/%h want 0/1/22", d, ov[d], dv[d], sb[d]);
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_basic();
        test_long_enable();
        test_ack();
        test_overrun();
        test_reset_midcycle_release();
        test_ack_on_cap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_sync.md
Name: data_sync

Overview:
- Receive-side bus synchronizer for multi-clock system data crossing into the CLK domain.
- Source domain holds UNSYNC_BUS stable and asserts level BUS_EN. BUS_EN passes through an NUM_STAGES flop chain, then an edge detector.
- The bus is captured exactly once per BUS_EN assertion, and a single-cycle ENABLE_PULSE is issued to the consumer.
- RST_n is driven by the CLK-domain reset synchronizer output, so deassertion is already CLK-aligned. A valid/ack flag with sticky overrun lets a slow consumer detect lost words.

Parameters:
- NUM_STAGES, 2, synchronizer depth on BUS_EN; legal range 2..4.
- BUS_WIDTH, 8, width of the data bus crossing the domain.

Ports:
- CLK  input  1  destination-domain clock.
- RST_n  input  1  reset, asynchronous, active-low; clock CLK.
- UNSYNC_BUS  input  BUS_WIDTH  source-domain data; stable from BUS_EN rise until BUS_EN fall.
- BUS_EN  input  1  source-domain level qualifier; high for at least NUM_STAGES+1 CLK cycles, low for at least NUM_STAGES+1 CLK cycles between words.
- DATA_ACK  input  1  consumer acknowledge; clears DATA_VALID.
- SYNC_BUS  output  BUS_WIDTH  registered captured word.
- ENABLE_PULSE  output  1  registered one-cycle strobe, coincident with SYNC_BUS update.
- DATA_VALID  output  1  high from capture until acknowledged.
- OVERRUN  output  1  sticky; a word was captured while DATA_VALID=1 and no DATA_ACK.

Behaviour:
- Reset (RST_n=0, async):
  - All sync stages, en_prev, SYNC_BUS, ENABLE_PULSE, DATA_VALID and OVERRUN clear to 0 immediately.
  - Release is synchronous to CLK by system construction.
- Sync chain:
  - stage[0] <= BUS_EN; stage[i] <= stage[i-1]; en_prev <= stage[NUM_STAGES-1].
  - Only stage[0] samples BUS_EN.
- Edge detect: cap = stage[NUM_STAGES-1] & ~en_prev (combinational, internal).
- Outputs on each posedge:
  - ENABLE_PULSE <= cap.
  - If cap, SYNC_BUS <= UNSYNC_BUS; otherwise SYNC_BUS holds.
- Latency:
  - Let edge E1 be the first CLK edge sampling BUS_EN=1.
  - ENABLE_PULSE and the new SYNC_BUS appear after edge E1+NUM_STAGES.
  - ENABLE_PULSE lasts exactly 1 cycle regardless of how long BUS_EN stays high.
- DATA_VALID:
  - cap sets it.
  - DATA_ACK with no cap clears it.
  - cap and DATA_ACK in the same cycle: stays 1, OVERRUN unaffected (ack consumed the old word).
- OVERRUN:
  - Set when cap=1 and DATA_VALID=1 and DATA_ACK=0. SYNC_BUS is still overwritten with the new word.
  - Cleared only by reset.
- BUS_EN fall: no output activity. en_prev follows; chain returns to 0 after NUM_STAGES+1 edges.
- BUS_EN high at reset release: treated as a new word. Pulse NUM_STAGES+1 edges after release.
- BUS_EN glitch shorter than one CLK period: may or may not be captured; at most one pulse results. This is not a protocol violation check.
- Reset mid-operation: any in-flight BUS_EN edge is lost. A BUS_EN still high afterwards is re-captured per the rule above.
- DATA_ACK while DATA_VALID=0: no effect.

Decomposition:
- Shared package cdc_pkg:
  - DEFAULT_SYNC_STAGES=2, DEFAULT_BUS_WIDTH=8.
  - A MIN_SYNC_STAGES=2 constant, checked by an elaboration-time assertion.
- Sub-module bit_sync (NUM_STAGES, WIDTH=1):
  - Async active-low reset flop chain carrying BUS_EN.
  - Reusable for other single-bit crossings.
- The edge detector, capture register and valid/overrun logic stay in data_sync.

Test Plan:
- Reset: drive RST_n=0 mid-cycle with BUS_EN=1 and UNSYNC_BUS=8'hFF -> all outputs 0 immediately; no ENABLE_PULSE while RST_n=0.
- Basic crossing, NUM_STAGES=2: UNSYNC_BUS=8'hA5, BUS_EN high sampled at edge E1 and held 6 cycles -> ENABLE_PULSE=1 for exactly the cycle after E1+2; SYNC_BUS=8'hA5 from the same edge; DATA_VALID=1.
- Long enable: hold BUS_EN high 20 cycles while changing UNSYNC_BUS to 8'h3C after the pulse -> exactly one pulse; SYNC_BUS stays 8'hA5.
- Ack handling: after the capture, pulse DATA_ACK one cycle -> DATA_VALID=0, OVERRUN=0. Second word 8'h5A -> DATA_VALID=1, SYNC_BUS=8'h5A.
- Overrun: two words 8'h11 then 8'h22 with no DATA_ACK -> SYNC_BUS=8'h22, OVERRUN=1 and stays 1 after a later DATA_ACK. In a second run, DATA_ACK on the exact cap cycle of word 2 -> OVERRUN stays 0, DATA_VALID=1.
- Depth sweep: NUM_STAGES=3 and 4 -> pulse appears after edge E1+3 and E1+4 respectively. BUS_EN held high through reset release -> pulse after release edge R+NUM_STAGES.
